// File: rtl/exception_sequencer_pkg.sv
`default_nettype none
// exception_sequencer_pkg: shared vector bytes, address-source select codes,
// cause encodings, FSM states and small helpers for the exception sequencer.
package exception_sequencer_pkg;

    localparam logic [7:0] NOOP_VEC = 8'd253;
    localparam logic [7:0] OVF_VEC  = 8'd254;
    localparam logic [7:0] DIV0_VEC = 8'd255;

    localparam logic [2:0] SRC_PC   = 3'b000;
    localparam logic [2:0] SRC_ALU  = 3'b001;
    localparam logic [2:0] SRC_NOOP = 3'b010;
    localparam logic [2:0] SRC_OVF  = 3'b011;
    localparam logic [2:0] SRC_DIV0 = 3'b100;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_NOP  = 2'b01,
        CAUSE_OVF  = 2'b10,
        CAUSE_DIV0 = 2'b11
    } cause_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SAVE = 3'd1,
        ST_ADDR = 3'd2,
        ST_LOAD = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    function automatic logic [2:0] cause_to_src(input cause_e c);
        case (c)
            CAUSE_NOP:  return SRC_NOOP;
            CAUSE_OVF:  return SRC_OVF;
            CAUSE_DIV0: return SRC_DIV0;
            default:    return SRC_PC;
        endcase
    endfunction

    function automatic logic [7:0] cause_to_vec(input cause_e c);
        case (c)
            CAUSE_NOP:  return NOOP_VEC;
            CAUSE_OVF:  return OVF_VEC;
            CAUSE_DIV0: return DIV0_VEC;
            default:    return 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/exception_sequencer_priority_enc.sv
`default_nettype none
// exc_priority_enc: picks one exception cause from simultaneous requests,
// div0 over ovf over nop, with a flag telling whether any request is present.
module exc_priority_enc
    import exception_sequencer_pkg::*;
(
    input  logic   nop_i,
    input  logic   ovf_i,
    input  logic   div0_i,
    output cause_e cause_o,
    output logic   valid_o
);

    always_comb begin
        cause_o = CAUSE_NONE;
        if (div0_i) begin
            cause_o = CAUSE_DIV0;
        end else if (ovf_i) begin
            cause_o = CAUSE_OVF;
        end else if (nop_i) begin
            cause_o = CAUSE_NOP;
        end
    end

    assign valid_o = nop_i | ovf_i | div0_i;

endmodule
`default_nettype wire

// File: rtl/exception_sequencer.sv
`default_nettype none
// exception_sequencer: owns the memory address-source select while an exception
// is serviced (EPC save, vector fetch, PC load). Build macro EXC_STATS_EN adds counters.
module exception_sequencer
    import exception_sequencer_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1,
    parameter logic [31:0] PC_INC  = 32'd4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  ctrl_src_add_mem,
    input  logic        exc_nop,
    input  logic        exc_ovf,
    input  logic        exc_div0,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_rdata,
    output logic [2:0]  src_add_mem,
    output logic        epc_wr,
    output logic [31:0] epc_val,
    output logic        pc_wr,
    output logic [31:0] pc_next,
    output logic        busy,
    output logic [1:0]  exc_cause
`ifdef EXC_STATS_EN
    ,
    output logic [7:0]  cnt_nop,
    output logic [7:0]  cnt_ovf,
    output logic [7:0]  cnt_div0,
    output logic [7:0]  drop_cnt
`endif
);

    localparam logic [2:0] LAST_WAIT = 3'(MEM_LAT - 1);

    state_e      state_q, state_d;
    logic [2:0]  wait_q, wait_d;
    cause_e      cause_q;
    cause_e      win_cause;
    logic        win_valid;
    logic        accept;
    logic [31:0] epc_q;
    logic [31:0] pcnext_q;
    logic        unused_rdata_hi;

    exc_priority_enc u_prio (
        .nop_i   (exc_nop),
        .ovf_i   (exc_ovf),
        .div0_i  (exc_div0),
        .cause_o (win_cause),
        .valid_o (win_valid)
    );

    assign accept          = (state_q == ST_IDLE) && win_valid;
    assign unused_rdata_hi = ^mem_rdata[31:8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = 3'd0;
        case (state_q)
            ST_IDLE: if (win_valid) state_d = ST_SAVE;
            ST_SAVE: state_d = ST_ADDR;
            ST_ADDR: begin
                if (wait_q == LAST_WAIT) begin
                    state_d = ST_LOAD;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            ST_LOAD: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // DONE already hands the select back to the control unit, but still stalls it.
    always_comb begin
        src_add_mem = ctrl_src_add_mem;
        epc_wr      = 1'b0;
        pc_wr       = 1'b0;
        busy        = 1'b1;
        case (state_q)
            ST_IDLE: busy = 1'b0;
            ST_SAVE: begin
                epc_wr      = 1'b1;
                src_add_mem = cause_to_src(cause_q);
            end
            ST_ADDR: src_add_mem = cause_to_src(cause_q);
            ST_LOAD: begin
                pc_wr       = 1'b1;
                src_add_mem = cause_to_src(cause_q);
            end
            default: ;
        endcase
    end

    // EPC is captured on acceptance and the vector byte on the last wait cycle,
    // so each value is already stable while its write strobe is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cause_q  <= CAUSE_NONE;
            epc_q    <= 32'd0;
            pcnext_q <= 32'd0;
        end else begin
            if (accept) begin
                cause_q <= win_cause;
                epc_q   <= pc_in - PC_INC;
            end
            if ((state_q == ST_ADDR) && (wait_q == LAST_WAIT)) begin
                pcnext_q <= {24'd0, mem_rdata[7:0]};
            end
        end
    end

    assign epc_val   = epc_q;
    assign pc_next   = pcnext_q;
    assign exc_cause = cause_q;

`ifdef EXC_STATS_EN
    logic [7:0] cnt_nop_q, cnt_ovf_q, cnt_div0_q, drop_q;
    logic [1:0] req_count;
    logic [1:0] drop_inc;
    logic [8:0] drop_sum;

    always_comb begin
        req_count = 2'(exc_nop) + 2'(exc_ovf) + 2'(exc_div0);
        drop_inc  = (state_q != ST_IDLE) ? req_count : (req_count - 2'(win_valid));
        drop_sum  = {1'b0, drop_q} + {7'd0, drop_inc};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_nop_q  <= 8'd0;
            cnt_ovf_q  <= 8'd0;
            cnt_div0_q <= 8'd0;
            drop_q     <= 8'd0;
        end else begin
            if (accept) begin
                case (win_cause)
                    CAUSE_NOP:  cnt_nop_q  <= sat_inc8(cnt_nop_q);
                    CAUSE_OVF:  cnt_ovf_q  <= sat_inc8(cnt_ovf_q);
                    CAUSE_DIV0: cnt_div0_q <= sat_inc8(cnt_div0_q);
                    default: ;
                endcase
            end
            drop_q <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    assign cnt_nop  = cnt_nop_q;
    assign cnt_ovf  = cnt_ovf_q;
    assign cnt_div0 = cnt_div0_q;
    assign drop_cnt = drop_q;
`endif

endmodule
`default_nettype wire
